// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Load/store sequencer between the CPU datapath and a byte-wide data RAM.
//   One word/halfword/byte access is accepted per handshake and carried out
//   as consecutive single-byte RAM cycles (little-endian). Load data is
//   zero- or sign-extended and returned with a one-cycle response pulse.
//
// Ports
//   clk_i           clock, rising edge
//   rst_n_i         asynchronous active-low reset
//   req_valid_i     CPU request valid
//   req_ready_o     high only in IDLE
//   req_we_i        1 = store, 0 = load
//   req_size_i      00 byte, 01 halfword, 10 word, 11 illegal
//   req_unsigned_i  load extension: 1 = zero-extend, 0 = sign-extend
//   req_addr_i      byte address of the lowest byte
//   req_wdata_i     store data, byte k = bits [8k+7:8k]
//   resp_valid_o    one-cycle completion pulse
//   resp_err_o      illegal size flag, valid with resp_valid_o
//   resp_rdata_o    extended load data (0 for stores and errors)
//   mem_addr_o      RAM byte address
//   mem_we_o        RAM byte write enable
//   mem_wdata_o     RAM write byte
//   mem_rdata_i     RAM read byte, combinational from mem_addr_o
module mem_access_ctrl #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [WIDTH-1:0]  req_wdata_i,
  output logic              resp_valid_o,
  output logic              resp_err_o,
  output logic [WIDTH-1:0]  resp_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [7:0]        mem_wdata_o,
  input  logic [7:0]        mem_rdata_i
);

  localparam int NBYTES = WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic                we_reg;
  logic [1:0]          size_reg;
  logic                uns_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [WIDTH-1:0]    wdata_reg;
  logic [1:0]          cnt_reg;
  logic [1:0]          last_reg;   // index of the final byte (nbytes-1)
  logic                err_reg;
  logic [WIDTH-1:0]    asm_reg;    // load assembly register

  logic                accept;
  logic [1:0]          last_from_size;
  logic [7:0]          wdata_bytes [NBYTES];
  logic [NBYTES-1:0]   cap_en;
  logic                fill_b, fill_h;
  logic [WIDTH-1:0]    load_ext;

  assign accept = (state_reg == IDLE) && req_valid_i;

  always_comb begin
    last_from_size = 2'd0;
    case (req_size_i)
      2'b01:   last_from_size = 2'd1;
      2'b10:   last_from_size = 2'd3;
      default: last_from_size = 2'd0;
    endcase
  end

  // Per-byte views of the latched store data and per-byte capture enables
  // for load assembly.
  generate
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_bytes
      assign wdata_bytes[gi] = wdata_reg[8*gi +: 8];
      assign cap_en[gi]      = (state_reg == XFER) && !we_reg && (cnt_reg == 2'(gi));
    end
  endgenerate

  // State register and request latch.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg <= IDLE;
      we_reg    <= 1'b0;
      size_reg  <= 2'b00;
      uns_reg   <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      cnt_reg   <= 2'd0;
      last_reg  <= 2'd0;
      err_reg   <= 1'b0;
      asm_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        we_reg    <= req_we_i;
        size_reg  <= req_size_i;
        uns_reg   <= req_unsigned_i;
        addr_reg  <= req_addr_i;
        wdata_reg <= req_wdata_i;
        cnt_reg   <= 2'd0;
        last_reg  <= last_from_size;
        err_reg   <= (req_size_i == 2'b11);
        asm_reg   <= '0;
      end else if (state_reg == XFER) begin
        cnt_reg <= cnt_reg + 2'd1;
        for (int i = 0; i < NBYTES; i++) begin
          if (cap_en[i]) begin
            asm_reg[8*i +: 8] <= mem_rdata_i;
          end
        end
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid_i) begin
          // Illegal size skips the RAM entirely and reports at once.
          state_next = (req_size_i == 2'b11) ? RESP : XFER;
        end
      end
      XFER: begin
        if (cnt_reg == last_reg) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Load extension from the assembled bytes.
  assign fill_b = !uns_reg && asm_reg[7];
  assign fill_h = !uns_reg && asm_reg[15];

  always_comb begin
    load_ext = asm_reg;
    case (size_reg)
      2'b00:   load_ext = {{(WIDTH-8){fill_b}}, asm_reg[7:0]};
      2'b01:   load_ext = {{(WIDTH-16){fill_h}}, asm_reg[15:0]};
      default: load_ext = asm_reg;
    endcase
  end

  // Outputs decode from state and latched request only, so nothing on
  // req_* reaches the RAM port combinationally.
  assign req_ready_o  = (state_reg == IDLE);
  assign resp_valid_o = (state_reg == RESP);
  assign resp_err_o   = (state_reg == RESP) && err_reg;
  assign resp_rdata_o = ((state_reg == RESP) && !we_reg && !err_reg) ? load_ext : '0;

  // Address wraps naturally modulo 2^ADDR_W.
  assign mem_addr_o  = (state_reg == XFER) ? (addr_reg + ADDR_W'(cnt_reg)) : '0;
  assign mem_we_o    = (state_reg == XFER) && we_reg;
  assign mem_wdata_o = ((state_reg == XFER) && we_reg) ? wdata_bytes[cnt_reg] : 8'h00;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [1:0]  req_size_i = 2'b00;
  logic        req_unsigned_i = 1'b0;
  logic [11:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        resp_valid_o;
  logic        resp_err_o;
  logic [31:0] resp_rdata_o;
  logic [11:0] mem_addr_o;
  logic        mem_we_o;
  logic [7:0]  mem_wdata_o;
  logic [7:0]  mem_rdata_i;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  mem_access_ctrl #(.WIDTH(32), .ADDR_W(12)) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .resp_valid_o   (resp_valid_o),
    .resp_err_o     (resp_err_o),
    .resp_rdata_o   (resp_rdata_o),
    .mem_addr_o     (mem_addr_o),
    .mem_we_o       (mem_we_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_rdata_i    (mem_rdata_i)
  );

  // Byte-wide RAM: combinational read, write on rising edge.
  logic [7:0] ram [0:4095];
  assign mem_rdata_i = ram[mem_addr_o];
  always @(posedge clk_i) begin
    if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
  end

  // Issue one request from IDLE and observe 8 cycles after the accept edge.
  // lat = cycle index (1-based after accept) of the response, -1 if none.
  // we_mask bit n-1 = mem_we_o seen high in cycle n.
  task automatic do_access(input logic we, input logic [1:0] size, input logic uns,
                           input logic [11:0] addr, input logic [31:0] wdata,
                           output int lat, output logic [31:0] rdata, output logic err,
                           output logic [7:0] we_mask, output int nresp);
    @(negedge clk_i);
    req_valid_i = 1'b1;
    req_we_i = we;
    req_size_i = size;
    req_unsigned_i = uns;
    req_addr_i = addr;
    req_wdata_i = wdata;
    @(posedge clk_i);
    #1;
    // Junk on the request lines after accept must be ignored.
    req_valid_i = 1'b0;
    req_we_i = ~we;
    req_size_i = 2'b11;
    req_unsigned_i = ~uns;
    req_addr_i = 12'hABC;
    req_wdata_i = 32'h5A5A5A5A;
    lat = -1;
    rdata = '0;
    err = 1'b0;
    we_mask = '0;
    nresp = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk_i);
      if (mem_we_o) we_mask[n-1] = 1'b1;
      if (resp_valid_o) begin
        nresp++;
        if (lat < 0) begin
          lat = n;
          rdata = resp_rdata_o;
          err = resp_err_o;
        end
      end
    end
    $display("txn we=%0d size=%0d uns=%0d addr=%03h wdata=%08h -> lat=%0d rdata=%08h err=%0d we_mask=%08b",
             we, size, uns, addr, wdata, lat, rdata, err, we_mask);
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checks++;
    if (req_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready_o); end
    checks++;
    if (resp_valid_o !== 1'b0 || resp_err_o !== 1'b0) begin
      failures++; $display("FAIL reset_resp got=%b%b exp=00", resp_valid_o, resp_err_o);
    end
    checks++;
    if (resp_rdata_o !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%08h exp=00000000", resp_rdata_o); end
    checks++;
    if (mem_we_o !== 1'b0 || mem_addr_o !== 12'h000 || mem_wdata_o !== 8'h00) begin
      failures++; $display("FAIL reset_mem got=we%b addr%03h wd%02h exp=we0 addr000 wd00", mem_we_o, mem_addr_o, mem_wdata_o);
    end
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    checks++;
    if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin
      failures++; $display("FAIL post_reset got=ready%b resp%b exp=ready1 resp0", req_ready_o, resp_valid_o);
    end
    $display("txn reset done");
  endtask

  task automatic test_store_word();
    int lat; logic [31:0] rd; logic err; logic [7:0] wm; int nr;
    do_access(1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF, lat, rd, err, wm, nr);
    checks++;
    if (lat !== 5 || nr !== 1) begin failures++; $display("FAIL sw_latency got=%0d/%0d exp=5/1", lat, nr); end
    checks++;
    if (wm !== 8'b0000_1111) begin failures++; $display("FAIL sw_we_cycles got=%08b exp=00001111", wm); end
    checks++;
    if (rd !== 32'h0 || err !== 1'b0) begin failures++; $display("FAIL sw_rdata got=%08h err%b exp=00000000 err0", rd, err); end
    checks++;
    if (ram[12'h010] !== 8'hEF || ram[12'h011] !== 8'hBE || ram[12'h012] !== 8'hAD || ram[12'h013] !== 8'hDE) begin
      failures++;
      $display("FAIL sw_ram got=%02h %02h %02h %02h exp=EF BE AD DE", ram[12'h010], ram[12'h011], ram[12'h012], ram[12'h013]);
    end
  endtask

  task automatic test_loads();
    int lat; logic [31:0] rd; logic err; logic [7:0] wm; int nr;
    do_access(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, lat, rd, err, wm, nr);
    checks++;
    if (rd !== 32'hDEADBEEF || lat !== 5 || wm !== 8'h00) begin
      failures++; $display("FAIL lw got=%08h lat%0d wm%08b exp=DEADBEEF lat5 wm0", rd, lat, wm);
    end
    do_access(1'b0, 2'b00, 1'b0, 12'h013, 32'h0, lat, rd, err, wm, nr);
    checks++;
    if (rd !== 32'hFFFFFFDE || lat !== 2) begin failures++; $display("FAIL lb_signed got=%08h lat%0d exp=FFFFFFDE lat2", rd, lat); end
    do_access(1'b0, 2'b00, 1'b1, 12'h013, 32'h0, lat, rd, err, wm, nr);
    checks++;
    if (rd !== 32'h000000DE) begin failures++; $display("FAIL lb_unsigned got=%08h exp=000000DE", rd); end
    do_access(1'b0, 2'b01, 1'b0, 12'h010, 32'h0, lat, rd, err, wm, nr);
    checks++;
    if (rd !== 32'hFFFFBEEF || lat !== 3) begin failures++; $display("FAIL lh_signed got=%08h lat%0d exp=FFFFBEEF lat3", rd, lat); end
    do_access(1'b0, 2'b01, 1'b1, 12'h012, 32'h0, lat, rd, err, wm, nr);
    checks++;
    if (rd !== 32'h0000DEAD || err !== 1'b0) begin failures++; $display("FAIL lh_unsigned got=%08h err%b exp=0000DEAD err0", rd, err); end
  endtask

  task automatic test_wrap();
    int lat; logic [31:0] rd; logic err; logic [7:0] wm; int nr;
    do_access(1'b1, 2'b01, 1'b0, 12'hFFF, 32'hCAFE1234, lat, rd, err, wm, nr);
    checks++;
    if (ram[12'hFFF] !== 8'h34 || ram[12'h000] !== 8'h12 || wm !== 8'b0000_0011) begin
      failures++; $display("FAIL wrap_store got=%02h %02h wm%08b exp=34 12 wm00000011", ram[12'hFFF], ram[12'h000], wm);
    end
    do_access(1'b0, 2'b01, 1'b0, 12'hFFF, 32'h0, lat, rd, err, wm, nr);
    checks++;
    if (rd !== 32'h00001234) begin failures++; $display("FAIL wrap_load got=%08h exp=00001234", rd); end
  endtask

  task automatic test_illegal();
    int lat; logic [31:0] rd; logic err; logic [7:0] wm; int nr;
    do_access(1'b1, 2'b11, 1'b0, 12'h020, 32'h11223344, lat, rd, err, wm, nr);
    checks++;
    if (wm !== 8'h00) begin failures++; $display("FAIL illegal_we got=%08b exp=00000000", wm); end
    checks++;
    if (lat !== 1 || err !== 1'b1 || nr !== 1 || rd !== 32'h0) begin
      failures++; $display("FAIL illegal_resp got=lat%0d err%b n%0d rd%08h exp=lat1 err1 n1 rd00000000", lat, err, nr, rd);
    end
  endtask

  task automatic test_back_to_back();
    int nacc, nresp, nlow;
    int acc_t [3];
    logic [11:0] addrs [3];
    logic [31:0] datas [3];
    logic acc_now;
    addrs[0] = 12'h100; addrs[1] = 12'h101; addrs[2] = 12'h102;
    datas[0] = 32'h11; datas[1] = 32'h22; datas[2] = 32'h33;
    nacc = 0; nresp = 0; nlow = 0;
    acc_t[0] = 0; acc_t[1] = 0; acc_t[2] = 0;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'b00; req_unsigned_i = 1'b0;
    req_addr_i = addrs[0]; req_wdata_i = datas[0];
    for (int t = 0; t < 12; t++) begin
      @(negedge clk_i);
      acc_now = 1'b0;
      if (resp_valid_o) nresp++;
      if (!req_ready_o) nlow++;
      if (req_ready_o && req_valid_i && nacc < 3) begin
        acc_t[nacc] = t; nacc++; acc_now = 1'b1;
      end
      @(posedge clk_i);
      #1;
      if (acc_now) begin
        if (nacc == 3) req_valid_i = 1'b0;
        else begin req_addr_i = addrs[nacc]; req_wdata_i = datas[nacc]; end
      end
    end
    $display("txn back_to_back accepts=%0d at %0d,%0d,%0d resps=%0d ready_low=%0d",
             nacc, acc_t[0], acc_t[1], acc_t[2], nresp, nlow);
    checks++;
    if (nacc !== 3 || acc_t[1] - acc_t[0] !== 3 || acc_t[2] - acc_t[1] !== 3) begin
      failures++; $display("FAIL b2b_spacing got=n%0d %0d,%0d,%0d exp=n3 spaced 3", nacc, acc_t[0], acc_t[1], acc_t[2]);
    end
    checks++;
    if (nresp !== 3) begin failures++; $display("FAIL b2b_resps got=%0d exp=3", nresp); end
    checks++;
    if (nlow !== 6) begin failures++; $display("FAIL b2b_ready_low got=%0d exp=6", nlow); end
    checks++;
    if (ram[12'h100] !== 8'h11 || ram[12'h101] !== 8'h22 || ram[12'h102] !== 8'h33) begin
      failures++; $display("FAIL b2b_ram got=%02h %02h %02h exp=11 22 33", ram[12'h100], ram[12'h101], ram[12'h102]);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; logic err; logic [7:0] wm; int nr;
    int nresp;
    // Known background at 0x200..0x203.
    do_access(1'b1, 2'b10, 1'b0, 12'h200, 32'hA5A5A5A5, lat, rd, err, wm, nr);
    @(negedge clk_i);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'b10; req_unsigned_i = 1'b0;
    req_addr_i = 12'h200; req_wdata_i = 32'h44332211;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b0;
    #1;
    checks++;
    if (mem_we_o !== 1'b0) begin failures++; $display("FAIL rstmid_we got=%b exp=0", mem_we_o); end
    nresp = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk_i);
      if (resp_valid_o) nresp++;
    end
    rst_n_i = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk_i);
      if (resp_valid_o) nresp++;
    end
    $display("txn reset_mid_store ram=%02h %02h %02h %02h resps=%0d",
             ram[12'h200], ram[12'h201], ram[12'h202], ram[12'h203], nresp);
    checks++;
    if (nresp !== 0) begin failures++; $display("FAIL rstmid_resp got=%0d exp=0", nresp); end
    checks++;
    if (req_ready_o !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b exp=1", req_ready_o); end
    checks++;
    if (ram[12'h200] !== 8'h11 || ram[12'h201] !== 8'h22 || ram[12'h202] !== 8'hA5 || ram[12'h203] !== 8'hA5) begin
      failures++;
      $display("FAIL rstmid_ram got=%02h %02h %02h %02h exp=11 22 A5 A5", ram[12'h200], ram[12'h201], ram[12'h202], ram[12'h203]);
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_loads();
    test_wrap();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Load/store sequencer between the CPU datapath and the byte-wide data RAM. Accepts one word, halfword or byte access per handshake. Performs it as consecutive single-byte RAM cycles, assembling or splitting the 32-bit data little-endian. Returns load data zero- or sign-extended, with a one-cycle response pulse, so the CPU never drives multi-byte RAM addressing itself.

## Interface
- WIDTH, 32: CPU data width; fixed at 32 (4 bytes).
- ADDR_W, 12: RAM byte-address width.
- clk_i  in  1  clock, all state changes on rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  CPU request valid.
- req_ready_o  out  1  controller can accept a request.
- req_we_i  in  1  1 = store, 0 = load.
- req_size_i  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_unsigned_i  in  1  load extension: 1 = zero-extend, 0 = sign-extend.
- req_addr_i  in  ADDR_W  byte address of the lowest byte.
- req_wdata_i  in  WIDTH  store data; byte k = bits [8k+7:8k].
- resp_valid_o  out  1  one-cycle completion pulse.
- resp_err_o  out  1  valid with resp_valid_o; 1 = illegal size.
- resp_rdata_o  out  WIDTH  extended load data; 0 for stores and errors.
- mem_addr_o  out  ADDR_W  RAM byte address.
- mem_we_o  out  1  RAM byte write enable.
- mem_wdata_o  out  8  RAM write byte.
- mem_rdata_i  in  8  RAM read byte, combinational from mem_addr_o.

## Operation
- States: IDLE, XFER, RESP.
- IDLE
  - req_ready_o = 1.
  - On req_valid_i && req_ready_o, latch we, size, unsigned, addr and wdata.
  - Set byte counter cnt = 0.
  - Set nbytes = 1, 2 or 4 from size.
  - Go to XFER; if size = 11, go straight to RESP with an error flagged.
- XFER, one byte per cycle
  - mem_addr_o = latched addr + cnt, modulo 2^ADDR_W (wraps 0xFFF -> 0x000).
  - Store: mem_we_o = 1 and mem_wdata_o = wdata byte cnt.
  - Load: mem_we_o = 0; at the clock edge, capture mem_rdata_i into assembly register byte cnt.
  - cnt increments each cycle.
  - When cnt = nbytes-1, go to RESP.
- RESP
  - resp_valid_o = 1 for exactly one cycle, then go to IDLE.
  - resp_err_o = 1 only for illegal size, with no RAM access performed.
- Load extension
  - Byte: the fill bit is 0 if unsigned, else bit 7 of byte 0; it fills bits 31:8.
  - Halfword: the fill bit is 0 if unsigned, else bit 15; it fills bits 31:16.
  - Word: returned unchanged.
- Misaligned addresses are legal and complete normally; bytes are simply sequential.
- No response backpressure: the CPU must consume resp_valid_o the cycle it is high.
- req_* inputs are ignored outside IDLE; the latched copy is used throughout the access.

## Timing
- Reset (async assert, sync-to-clock release): state IDLE, req_ready_o = 1, resp_valid_o = 0, resp_err_o = 0, resp_rdata_o = 0, mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0.
- Reset mid-XFER aborts the access immediately: no further RAM writes and no response. Bytes already written stay written.
- Accept at edge E0. Byte k is on the RAM port during cycle k+1 after E0. resp_valid_o is high during cycle nbytes+1.
- Latency from accept to response: byte 2 cycles, halfword 3, word 5, illegal 1.
- req_ready_o is high only in IDLE, so back-to-back throughput is nbytes+2 cycles per access.
- mem_we_o is high only in XFER for stores; never high in IDLE or RESP.
- All outputs are registered or decoded from state/counter only; no combinational path from req_* to mem_*.

## Test plan
- Store word
  - Stimulus: addr 0x010, wdata 0xDEADBEEF, size 10.
  - Required: RAM writes 0x010=EF, 0x011=BE, 0x012=AD, 0x013=DE in 4 consecutive cycles; resp_valid_o 5 cycles after accept with rdata 0.
- Loads after that store
  - Load word 0x010 -> 0xDEADBEEF.
  - Load signed byte 0x013 -> 0xFFFFFFDE.
  - Load unsigned byte 0x013 -> 0x000000DE.
  - Load signed halfword 0x010 -> 0xFFFFBEEF.
- Wrap-around: store halfword 0x1234 at 0xFFF -> writes 0xFFF=34 and 0x000=12; loading halfword 0xFFF returns 0x00001234.
- Illegal size 11 with req_we_i = 1 -> no mem_we_o pulse; resp_valid_o and resp_err_o high one cycle after accept.
- Back-to-back: hold req_valid_i high with three byte stores -> req_ready_o low during XFER/RESP; accepts spaced 3 cycles apart; exactly 3 responses.
- Reset mid-word-store: assert rst_n_i after 2 bytes -> mem_we_o drops immediately; only 2 bytes modified; no resp_valid_o; req_ready_o = 1 after release.
